// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared constants, address field positions, FSM state
//                encoding and address decode helpers for the BRAM write-back
//                path of the NTT engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    localparam int NUM_BU   = 8;   // butterfly lanes per group
    localparam int NUM_BANK = 8;   // BRAM banks per port
    localparam int ADDR_W   = 8;   // core address width

    // Core address layout: {bank[7:5], row[4:0]}
    localparam int BANK_LSB = 5;
    localparam int BANK_W   = 3;
    localparam int ROW_LSB  = 0;
    localparam int ROW_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
        return a[BANK_LSB +: BANK_W];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[ROW_LSB +: ROW_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_decode_write_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_decode_write_if
//  Description : Bundle of issue-side, butterfly-result and BRAM write-port
//                signals for bram_decode_write.
//                master : environment (drives issue/BU inputs, sees writes)
//                slave  : bram_decode_write
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_decode_write_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5
);
    import ntt_pkg::*;

    logic                                 start_i;
    logic                                 issue_i;
    logic                                 last_i;
    logic [NUM_BU-1:0][ADDR_W-1:0]        addr_core_i;
    logic [ADDR_W-1:0]                    olen_i;
    logic                                 bu_valid_i;
    logic [NUM_BU-1:0][DATA_WIDTH-1:0]    res_a_i;
    logic [NUM_BU-1:0][DATA_WIDTH-1:0]    res_b_i;
    logic [NUM_BANK-1:0]                  we_a_o;
    logic [NUM_BANK-1:0]                  we_b_o;
    logic [NUM_BANK-1:0][ADW-1:0]         waddr_a_o;
    logic [NUM_BANK-1:0][ADW-1:0]         waddr_b_o;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  wdata_a_o;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  wdata_b_o;
    logic                                 done_write_o;
    logic                                 err_o;

    modport master (
        output start_i, issue_i, last_i, addr_core_i, olen_i,
               bu_valid_i, res_a_i, res_b_i,
        input  we_a_o, we_b_o, waddr_a_o, waddr_b_o, wdata_a_o, wdata_b_o,
               done_write_o, err_o
    );

    modport slave (
        input  start_i, issue_i, last_i, addr_core_i, olen_i,
               bu_valid_i, res_a_i, res_b_i,
        output we_a_o, we_b_o, waddr_a_o, waddr_b_o, wdata_a_o, wdata_b_o,
               done_write_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/wr_crossbar_8x8.sv
`default_nettype none
// ============================================================================
//  Module      : wr_crossbar_8x8
//  Description : Routes 8 lanes of (bank, row, data) onto 8 per-bank write
//                ports. Combinational. When two lanes hit the same bank the
//                lowest-numbered lane keeps it and o_conflict is raised.
//  Ports       : i_en       - group valid; all outputs zero when low
//                i_bank/i_row/i_data - per-lane target and payload
//                o_we/o_row/o_data   - per-bank write strobe, row, data
//                o_conflict - two or more lanes targeted one bank
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_crossbar_8x8
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5
) (
    input  wire logic                                 i_en,
    input  wire logic [NUM_BU-1:0][BANK_W-1:0]        i_bank,
    input  wire logic [NUM_BU-1:0][ROW_W-1:0]         i_row,
    input  wire logic [NUM_BU-1:0][DATA_WIDTH-1:0]    i_data,
    output logic      [NUM_BANK-1:0]                  o_we,
    output logic      [NUM_BANK-1:0][ADW-1:0]         o_row,
    output logic      [NUM_BANK-1:0][DATA_WIDTH-1:0]  o_data,
    output logic                                      o_conflict
);

    always_comb begin
        o_we       = '0;
        o_row      = '0;
        o_data     = '0;
        o_conflict = 1'b0;
        if (i_en) begin
            // Ascending lane order: a bank already claimed belongs to a
            // lower lane, so later claimants only flag the conflict.
            for (int l = 0; l < NUM_BU; l++) begin
                if (o_we[i_bank[l]]) begin
                    o_conflict = 1'b1;
                end else begin
                    o_we[i_bank[l]]   = 1'b1;
                    o_row[i_bank[l]]  = ADW'(i_row[l]);
                    o_data[i_bank[l]] = i_data[l];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_decode_write.sv
`default_nettype none
// ============================================================================
//  Module      : bram_decode_write
//  Description : Write-back side of the NTT BRAM datapath. Delays issued
//                lane addresses to line up with butterfly results, decodes
//                bank/row for operand A (addr) and B (addr+olen), crossbars
//                results onto the banks and registers the write ports.
//  Ports       : clk_i, rst_i (sync, active high)
//                bus (slave) - start/issue/last, addresses, olen, BU results,
//                              per-bank write ports, done pulse, sticky err
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_decode_write
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5,
    parameter int BU_LAT     = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    bram_decode_write_if.slave bus
);

    localparam int CNT_W = 4;

    state_e                                   r_state_q, w_state_d;
    logic [CNT_W-1:0]                         r_cnt_q,   w_cnt_d;
    logic [BU_LAT-1:0]                        r_dl_vld_q,  w_dl_vld_d;
    logic [BU_LAT-1:0][NUM_BU-1:0][ADDR_W-1:0] r_dl_addr_q, w_dl_addr_d;
    logic [BU_LAT-1:0][ADDR_W-1:0]            r_dl_olen_q, w_dl_olen_d;

    logic                                     w_accept;
    logic                                     w_misalign;
    logic                                     w_wr_en;
    logic [NUM_BU-1:0][BANK_W-1:0]            w_bank_a, w_bank_b;
    logic [NUM_BU-1:0][ROW_W-1:0]             w_row_a,  w_row_b;
    logic [NUM_BU-1:0][ADDR_W-1:0]            w_addr_b;
    logic [NUM_BANK-1:0]                      w_xa_we, w_xb_we;
    logic [NUM_BANK-1:0][ADW-1:0]             w_xa_row, w_xb_row;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0]      w_xa_data, w_xb_data;
    logic                                     w_conf_a, w_conf_b;

    logic [NUM_BANK-1:0]                      r_we_a_q, r_we_b_q;
    logic [NUM_BANK-1:0][ADW-1:0]             r_waddr_a_q, r_waddr_b_q;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0]      r_wdata_a_q, r_wdata_b_q;
    logic                                     r_err_q, w_err_d;

    // Issues only count in RUN; DONE and DRAIN drop them.
    assign w_accept = bus.issue_i && (r_state_q == ST_RUN);

    // ---------------- FSM ----------------
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            ST_IDLE:  if (bus.start_i) w_state_d = ST_RUN;
            ST_RUN: begin
                if (w_accept && bus.last_i) begin
                    w_state_d = ST_DRAIN;
                    w_cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // BU_LAT cycles here puts DONE BU_LAT+1 cycles after the
                // last issue, i.e. on the cycle its write is visible.
                if (r_cnt_q == CNT_W'(BU_LAT - 1)) w_state_d = ST_DONE;
                else                               w_cnt_d   = r_cnt_q + 1'b1;
            end
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // ---------------- Address delay line ----------------
    always_comb begin
        w_dl_vld_d     = '0;
        w_dl_addr_d    = '0;
        w_dl_olen_d    = '0;
        w_dl_vld_d[0]  = w_accept;
        w_dl_addr_d[0] = bus.addr_core_i;
        w_dl_olen_d[0] = bus.olen_i;
        for (int i = 1; i < BU_LAT; i++) begin
            w_dl_vld_d[i]  = r_dl_vld_q[i-1];
            w_dl_addr_d[i] = r_dl_addr_q[i-1];
            w_dl_olen_d[i] = r_dl_olen_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_dl_vld_q <= '0;
        else       r_dl_vld_q <= w_dl_vld_d;
    end

    // Payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk_i) begin
        r_dl_addr_q <= w_dl_addr_d;
        r_dl_olen_q <= w_dl_olen_d;
    end

    // ---------------- Alignment and decode ----------------
    assign w_misalign = r_dl_vld_q[BU_LAT-1] != bus.bu_valid_i;
    assign w_wr_en    = r_dl_vld_q[BU_LAT-1] && bus.bu_valid_i;

    always_comb begin
        w_bank_a = '0;
        w_bank_b = '0;
        w_row_a  = '0;
        w_row_b  = '0;
        w_addr_b = '0;
        for (int l = 0; l < NUM_BU; l++) begin
            w_addr_b[l] = r_dl_addr_q[BU_LAT-1][l] + r_dl_olen_q[BU_LAT-1];
            w_bank_a[l] = bank_of(r_dl_addr_q[BU_LAT-1][l]);
            w_row_a[l]  = row_of(r_dl_addr_q[BU_LAT-1][l]);
            w_bank_b[l] = bank_of(w_addr_b[l]);
            w_row_b[l]  = row_of(w_addr_b[l]);
        end
    end

    wr_crossbar_8x8 #(.DATA_WIDTH(DATA_WIDTH), .ADW(ADW)) u_xbar_a (
        .i_en       (w_wr_en),
        .i_bank     (w_bank_a),
        .i_row      (w_row_a),
        .i_data     (bus.res_a_i),
        .o_we       (w_xa_we),
        .o_row      (w_xa_row),
        .o_data     (w_xa_data),
        .o_conflict (w_conf_a)
    );

    wr_crossbar_8x8 #(.DATA_WIDTH(DATA_WIDTH), .ADW(ADW)) u_xbar_b (
        .i_en       (w_wr_en),
        .i_bank     (w_bank_b),
        .i_row      (w_row_b),
        .i_data     (bus.res_b_i),
        .o_we       (w_xb_we),
        .o_row      (w_xb_row),
        .o_data     (w_xb_data),
        .o_conflict (w_conf_b)
    );

    // ---------------- Registered write ports ----------------
    assign w_err_d = r_err_q | w_misalign | w_conf_a | w_conf_b;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we_a_q    <= '0;
            r_we_b_q    <= '0;
            r_waddr_a_q <= '0;
            r_waddr_b_q <= '0;
            r_wdata_a_q <= '0;
            r_wdata_b_q <= '0;
            r_err_q     <= 1'b0;
        end else begin
            r_we_a_q    <= w_xa_we;
            r_we_b_q    <= w_xb_we;
            r_waddr_a_q <= w_xa_row;
            r_waddr_b_q <= w_xb_row;
            r_wdata_a_q <= w_xa_data;
            r_wdata_b_q <= w_xb_data;
            r_err_q     <= w_err_d;
        end
    end

    assign bus.we_a_o       = r_we_a_q;
    assign bus.we_b_o       = r_we_b_q;
    assign bus.waddr_a_o    = r_waddr_a_q;
    assign bus.waddr_b_o    = r_waddr_b_q;
    assign bus.wdata_a_o    = r_wdata_a_q;
    assign bus.wdata_b_o    = r_wdata_b_q;
    assign bus.err_o        = r_err_q;
    assign bus.done_write_o = (r_state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bram_decode_write.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_decode_write
//  Description : Directed scoreboard bench for bram_decode_write. Issue
//                tasks queue the expected registered write; a negedge
//                monitor pops and compares whenever a write appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_decode_write;
    import ntt_pkg::*;

    localparam int DW     = 12;
    localparam int AW     = 5;
    localparam int BU_LAT = 4;

    typedef struct {
        int                        cyc;
        logic [7:0]                we_a, we_b;
        logic [7:0][AW-1:0]        wa_a, wa_b;
        logic [7:0][DW-1:0]        wd_a, wd_b;
        logic                      done;
    } exp_t;

    typedef struct {
        int                        cyc;
        logic [7:0][DW-1:0]        ra, rb;
    } bu_t;

    logic clk;
    logic rst;
    int   cur;
    int   checks;
    int   errors;
    int   done_cnt;

    exp_t exp_q[$];
    bu_t  bu_q[$];
    exp_t me;

    logic [7:0][7:0]   g_addr;
    logic [7:0]        g_olen;
    logic [7:0][DW-1:0] g_ra, g_rb;
    exp_t              g_e;

    bram_decode_write_if #(.DATA_WIDTH(DW), .ADW(AW)) bus ();

    bram_decode_write #(.DATA_WIDTH(DW), .ADW(AW), .BU_LAT(BU_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // Drives BU results scheduled for this cycle, then advances one cycle.
    task automatic tick();
        if (bu_q.size() > 0 && bu_q[0].cyc == cur) begin
            bus.bu_valid_i = 1'b1;
            bus.res_a_i    = bu_q[0].ra;
            bus.res_b_i    = bu_q[0].rb;
            bu_q.delete(0);
        end else begin
            bus.bu_valid_i = 1'b0;
            bus.res_a_i    = '0;
            bus.res_b_i    = '0;
        end
        @(posedge clk);
        #1;
        cur++;
        bus.start_i = 1'b0;
        bus.issue_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start();
        bus.start_i = 1'b1;
        tick();
    endtask

    task automatic issue(input logic lst, input logic sched, input int off,
                         input logic push_exp);
        bu_t b;
        bus.issue_i     = 1'b1;
        bus.last_i      = lst;
        bus.addr_core_i = g_addr;
        bus.olen_i      = g_olen;
        if (sched) begin
            b.cyc = cur + BU_LAT + off;
            b.ra  = g_ra;
            b.rb  = g_rb;
            bu_q.push_back(b);
        end
        if (push_exp) begin
            g_e.cyc  = cur + BU_LAT + 1;
            g_e.done = lst;
            exp_q.push_back(g_e);
        end
        tick();
    endtask

    // Lane i at bank i row 0, B at bank i row 16.
    task automatic set_basic();
        g_olen = 8'h10;
        for (int i = 0; i < 8; i++) begin
            g_addr[i]   = 8'(i * 32);
            g_ra[i]     = DW'(i);
            g_rb[i]     = DW'(100 + i);
            g_e.wa_a[i] = 5'd0;
            g_e.wa_b[i] = 5'd16;
            g_e.wd_a[i] = DW'(i);
            g_e.wd_b[i] = DW'(100 + i);
        end
        g_e.we_a = 8'hFF;
        g_e.we_b = 8'hFF;
    endtask

    // Monitor: every presented write is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.done_write_o) done_cnt++;
        if (bus.we_a_o != 8'h00 || bus.we_b_o != 8'h00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write we_a=%h we_b=%h (none expected)",
                         bus.we_a_o, bus.we_b_o);
            end else begin
                me = exp_q.pop_front();
                chk("write_cycle", 0, 32'(cur), 32'(me.cyc));
                chk("we_a", 0, 32'(bus.we_a_o), 32'(me.we_a));
                chk("we_b", 0, 32'(bus.we_b_o), 32'(me.we_b));
                for (int k = 0; k < 8; k++) begin
                    if (me.we_a[k]) begin
                        chk("waddr_a", k, 32'(bus.waddr_a_o[k]), 32'(me.wa_a[k]));
                        chk("wdata_a", k, 32'(bus.wdata_a_o[k]), 32'(me.wd_a[k]));
                    end
                    if (me.we_b[k]) begin
                        chk("waddr_b", k, 32'(bus.waddr_b_o[k]), 32'(me.wa_b[k]));
                        chk("wdata_b", k, 32'(bus.wdata_b_o[k]), 32'(me.wd_b[k]));
                    end
                end
                chk("done_with_write", 0, 32'(bus.done_write_o), 32'(me.done));
            end
        end else if (bus.done_write_o) begin
            checks++;
            errors++;
            $display("FAIL done_without_write got 1 expected 0");
        end
    end

    initial begin
        int d0;
        checks = 0; errors = 0; done_cnt = 0; cur = 0;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.issue_i = 1'b0; bus.last_i = 1'b0;
        bus.addr_core_i = '0; bus.olen_i = '0;
        bus.bu_valid_i = 1'b0; bus.res_a_i = '0; bus.res_b_i = '0;
        g_e.we_a = '0; g_e.we_b = '0; g_e.wa_a = '0; g_e.wa_b = '0;
        g_e.wd_a = '0; g_e.wd_b = '0; g_e.cyc = 0; g_e.done = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_we_a", 0, 32'(bus.we_a_o), 0);
        chk("rst_we_b", 0, 32'(bus.we_b_o), 0);
        chk("rst_waddr_nonzero", 0, 32'(bus.waddr_a_o != '0), 0);
        chk("rst_done", 0, 32'(bus.done_write_o), 0);
        chk("rst_err", 0, 32'(bus.err_o), 0);

        // Issue while IDLE must be ignored (would otherwise misalign)
        set_basic();
        issue(1'b1, 1'b0, 0, 1'b0);
        idle(BU_LAT + 3);
        chk("idle_issue_err", 0, 32'(bus.err_o), 0);

        // Single aligned group
        set_basic();
        start();
        issue(1'b1, 1'b1, 0, 1'b1);
        idle(BU_LAT + 3);
        chk("basic_err", 0, 32'(bus.err_o), 0);

        // Wrap of addr+olen past 255
        g_olen    = 8'h20;
        g_addr[0] = 8'hF0;
        for (int i = 1; i < 8; i++) g_addr[i] = 8'((i - 1) * 32 + 16);
        for (int i = 0; i < 8; i++) begin
            g_ra[i]     = DW'(300 + i);
            g_rb[i]     = DW'(400 + i);
            g_e.wa_a[i] = 5'd16;
            g_e.wa_b[i] = 5'd16;
            g_e.wd_b[i] = DW'(400 + i);
            g_e.wd_a[i] = (i == 7) ? DW'(300) : DW'(300 + i + 1);
        end
        g_e.we_a = 8'hFF;
        g_e.we_b = 8'hFF;
        start();
        issue(1'b1, 1'b1, 0, 1'b1);
        idle(BU_LAT + 3);
        chk("wrap_err", 0, 32'(bus.err_o), 0);

        // Full pass: 16 back-to-back groups, B rotated by s banks
        d0 = done_cnt;
        start();
        for (int g = 0; g < 16; g++) begin
            int s;
            s      = (g % 7) + 1;
            g_olen = 8'(s * 32);
            for (int i = 0; i < 8; i++) begin
                g_addr[i]   = 8'(i * 32 + g);
                g_ra[i]     = DW'(g * 8 + i);
                g_rb[i]     = DW'(1000 + g * 8 + i);
                g_e.wa_a[i] = 5'(g);
                g_e.wa_b[i] = 5'(g);
                g_e.wd_a[i] = DW'(g * 8 + i);
                g_e.wd_b[i] = DW'(1000 + g * 8 + ((i + 8 - s) % 8));
            end
            g_e.we_a = 8'hFF;
            g_e.we_b = 8'hFF;
            issue(g == 15, 1'b1, 0, 1'b1);
        end
        idle(BU_LAT + 3);
        chk("pass_done_pulses", 0, 32'(done_cnt - d0), 1);
        chk("pass_err", 0, 32'(bus.err_o), 0);

        // Conflict: lanes 0 and 1 both at address 5
        g_olen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            g_addr[i]   = (i < 2) ? 8'd5 : 8'(i * 32);
            g_ra[i]     = DW'(10 + i);
            g_rb[i]     = DW'(50 + i);
            g_e.wa_a[i] = (i == 0) ? 5'd5 : 5'd0;
            g_e.wa_b[i] = (i == 0) ? 5'd5 : 5'd0;
            g_e.wd_a[i] = (i == 1) ? DW'(0) : DW'(10 + i);
            g_e.wd_b[i] = (i == 1) ? DW'(0) : DW'(50 + i);
        end
        g_e.we_a = 8'hFD;
        g_e.we_b = 8'hFD;
        start();
        issue(1'b1, 1'b1, 0, 1'b1);
        idle(BU_LAT + 3);
        chk("conflict_err", 0, 32'(bus.err_o), 1);

        // Reset in DRAIN: pending group dropped, no done, new start works
        set_basic();
        start();
        issue(1'b1, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_we_a", 0, 32'(bus.we_a_o), 0);
        chk("mid_rst_we_b", 0, 32'(bus.we_b_o), 0);
        chk("mid_rst_done", 0, 32'(bus.done_write_o), 0);
        chk("mid_rst_err", 0, 32'(bus.err_o), 0);
        d0 = done_cnt;
        idle(BU_LAT + 3);
        chk("mid_rst_no_done", 0, 32'(done_cnt - d0), 0);
        start();
        issue(1'b1, 1'b1, 0, 1'b1);
        idle(BU_LAT + 3);
        chk("restart_err", 0, 32'(bus.err_o), 0);

        // Misalignment: BU result one cycle early, no write may happen
        set_basic();
        start();
        issue(1'b0, 1'b1, -1, 1'b0);
        idle(BU_LAT + 3);
        chk("misalign_err", 0, 32'(bus.err_o), 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("final_rst_err", 0, 32'(bus.err_o), 0);
        chk("pending_writes", 0, 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
